// File: rtl/id_hazard_ctrl.sv
// Load-use hazard and branch-flush controller for the ID stage of the 5-stage pipeline.
// Optional stall/flush statistics counters are built only when HAZARD_STATS_EN is defined.
module id_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             branch_taken_i,
  output logic             noop_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2
  } state_t;

  // Bubbles still owed after the detection cycle, which is itself the first bubble
  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_downCnt;
  logic [3:0] w_nextDownCnt;
  logic       w_rs1Match;
  logic       w_rs2Match;
  logic       w_hazard;

  // A load into x0 never produces a value worth waiting for
  assign w_rs1Match = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign w_rs2Match = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign w_hazard   = ex_memread_i & (ex_rd_i != 5'd0) & (w_rs1Match | w_rs2Match);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_downCnt <= 4'd0;
    end else begin
      r_state   <= w_nextState;
      r_downCnt <= w_nextDownCnt;
    end
  end

  // Bubble outputs are the default; only a hazard-free RUN cycle lets the pipeline advance
  always_comb begin
    w_nextState   = r_state;
    w_nextDownCnt = r_downCnt;
    noop_o        = 1'b1;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    if (!start_i) begin
      w_nextState   = S_IDLE;
      w_nextDownCnt = 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nextState = S_RUN;
        end
        S_RUN: begin
          if (w_hazard) begin
            if (STALL_CYCLES > 1) begin
              w_nextState   = S_STALL;
              w_nextDownCnt = STALL_LOAD;
            end
          end else begin
            noop_o       = 1'b0;
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = branch_taken_i;
          end
        end
        S_STALL: begin
          if (r_downCnt <= 4'd1) begin
            w_nextState   = S_RUN;
            w_nextDownCnt = 4'd0;
          end else begin
            w_nextDownCnt = r_downCnt - 4'd1;
          end
        end
        default: begin
          w_nextState   = S_IDLE;
          w_nextDownCnt = 4'd0;
        end
      endcase
    end
  end

  assign state_o = r_state;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             w_stallEvent;

  assign w_stallEvent = ((r_state == S_RUN) || (r_state == S_STALL)) && noop_o;

  // Both counters saturate rather than wrap so long runs never under-report
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stallEvent && (r_stallCnt != '1)) begin
        r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
      if (ifid_flush_o && (r_flushCnt != '1)) begin
        r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = r_stallCnt;
  assign flush_cnt_o = r_flushCnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed self-checking bench for id_hazard_ctrl; three instances share stimulus and
// differ in STALL_CYCLES (1, 3, 4). The first uses narrow counters to reach saturation.
module tb_id_hazard_ctrl;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       start_i;
  logic [4:0] id_rs1_i;
  logic [4:0] id_rs2_i;
  logic       id_use_rs1_i;
  logic       id_use_rs2_i;
  logic       ex_memread_i;
  logic [4:0] ex_rd_i;
  logic       branch_taken_i;

  logic        noop1, pcw1, ifidw1, flush1;
  logic [1:0]  state1;
  logic [1:0]  stallCnt1, flushCnt1;
  logic        noop3, pcw3, ifidw3, flush3;
  logic [1:0]  state3;
  logic [15:0] stallCnt3, flushCnt3;
  logic        noop4, pcw4, ifidw4, flush4;
  logic [1:0]  state4;
  logic [15:0] stallCnt4, flushCnt4;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk_i = ~clk_i;

  id_hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(2)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .branch_taken_i(branch_taken_i),
    .noop_o(noop1), .pc_write_o(pcw1), .ifid_write_o(ifidw1), .ifid_flush_o(flush1),
    .state_o(state1), .stall_cnt_o(stallCnt1), .flush_cnt_o(flushCnt1)
  );

  id_hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .branch_taken_i(branch_taken_i),
    .noop_o(noop3), .pc_write_o(pcw3), .ifid_write_o(ifidw3), .ifid_flush_o(flush3),
    .state_o(state3), .stall_cnt_o(stallCnt3), .flush_cnt_o(flushCnt3)
  );

  id_hazard_ctrl #(.STALL_CYCLES(4), .CNT_W(16)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .branch_taken_i(branch_taken_i),
    .noop_o(noop4), .pc_write_o(pcw4), .ifid_write_o(ifidw4), .ifid_flush_o(flush4),
    .state_o(state4), .stall_cnt_o(stallCnt4), .flush_cnt_o(flushCnt4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic memread, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic useRs1, input logic useRs2, input logic branch);
    start_i        = start;
    ex_memread_i   = memread;
    ex_rd_i        = rd;
    id_rs1_i       = rs1;
    id_rs2_i       = rs2;
    id_use_rs1_i   = useRs1;
    id_use_rs2_i   = useRs2;
    branch_taken_i = branch;
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Leaves every instance in RUN with quiet inputs, 1 time unit after an edge
  task automatic doReset();
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
  endtask

  function automatic logic [31:0] expCnt(input int n);
    return STATS ? 32'(n) : 32'd0;
  endfunction

  initial begin
    rst_i = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("rst_state", state1, 0);
    checkOutput("rst_noop", noop1, 1);
    checkOutput("rst_pcw", pcw1, 0);
    checkOutput("rst_ifidw", ifidw1, 0);
    checkOutput("rst_flush", flush1, 0);
    checkOutput("rst_stallcnt", stallCnt1, 0);
    checkOutput("rst_flushcnt", flushCnt1, 0);

    nextCycle();
    rst_i = 1'b0;
    nextCycle();
    checkOutput("idle_hold", state1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("idle_start_state", state1, 0);
    checkOutput("idle_start_noop", noop1, 1);
    nextCycle();
    checkOutput("run_state", state1, 1);
    checkOutput("run_noop", noop1, 0);
    checkOutput("run_pcw", pcw1, 1);
    checkOutput("run_ifidw", ifidw1, 1);

    // Single-cycle stall with STALL_CYCLES=1
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 0);
    #2;
    checkOutput("s1_haz_noop", noop1, 1);
    checkOutput("s1_haz_pcw", pcw1, 0);
    checkOutput("s1_haz_ifidw", ifidw1, 0);
    checkOutput("s1_haz_state", state1, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("s1_after_noop", noop1, 0);
    checkOutput("s1_after_pcw", pcw1, 1);
    checkOutput("s1_after_state", state1, 1);
    checkOutput("s1_stallcnt", stallCnt1, expCnt(1));

    // Three-bubble stall, then a back-to-back hazard
    doReset();
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 0);
    #2;
    checkOutput("s3_c0_noop", noop3, 1);
    checkOutput("s3_c0_state", state3, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("s3_c1_state", state3, 2);
    checkOutput("s3_c1_noop", noop3, 1);
    checkOutput("s3_c1_pcw", pcw3, 0);
    nextCycle();
    #2;
    checkOutput("s3_c2_state", state3, 2);
    checkOutput("s3_c2_noop", noop3, 1);
    nextCycle();
    #2;
    checkOutput("s3_c3_state", state3, 1);
    checkOutput("s3_c3_noop", noop3, 0);
    checkOutput("s3_stallcnt", stallCnt3, expCnt(3));
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 0);
    #1;
    checkOutput("s3_b2b_noop", noop3, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("s3_b2b_state", state3, 2);

    // rd = x0 and unused operands never stall
    doReset();
    applyStimulus(1, 1, 0, 0, 0, 1, 0, 0);
    #2;
    checkOutput("x0_noop", noop1, 0);
    checkOutput("x0_pcw", pcw1, 1);
    applyStimulus(1, 1, 7, 7, 3, 0, 1, 0);
    #2;
    checkOutput("unused_rs1_noop", noop1, 0);
    applyStimulus(1, 1, 7, 7, 3, 1, 1, 0);
    #2;
    checkOutput("rs1_haz_noop", noop1, 1);
    applyStimulus(1, 0, 7, 7, 3, 1, 1, 0);
    #2;
    checkOutput("no_memread_noop", noop1, 0);

    // Branch flush, and branch masked by a hazard
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("br_flush", flush1, 1);
    checkOutput("br_noop", noop1, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("br_flush_off", flush1, 0);
    checkOutput("br_flushcnt", flushCnt1, expCnt(1));
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 1);
    #2;
    checkOutput("brhaz_flush", flush1, 0);
    checkOutput("brhaz_noop", noop1, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("brhaz_flushcnt", flushCnt1, expCnt(1));

    // Dropping start in RUN returns to IDLE with bubble outputs
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    checkOutput("stop_noop", noop1, 1);
    checkOutput("stop_pcw", pcw1, 0);
    checkOutput("stop_flush", flush1, 0);
    nextCycle();
    #2;
    checkOutput("stop_state", state1, 0);

    // Reset in the second STALL cycle of a four-bubble stall
    doReset();
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 0);
    #2;
    checkOutput("s4_c0_noop", noop4, 1);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("s4_c1_state", state4, 2);
    nextCycle();
    #1;
    checkOutput("s4_c2_state", state4, 2);
    checkOutput("s4_pre_stallcnt", stallCnt4, expCnt(2));
    rst_i = 1'b1;
    #1;
    checkOutput("s4_rst_state", state4, 0);
    checkOutput("s4_rst_stallcnt", stallCnt4, 0);
    checkOutput("s4_rst_flushcnt", flushCnt4, 0);
    checkOutput("s4_rst_noop", noop4, 1);
    checkOutput("s4_rst_pcw", pcw4, 0);
    rst_i = 1'b0;
    nextCycle();
    #1;
    checkOutput("s4_restart_state", state4, 1);

    // Narrow counters saturate at 3
    doReset();
    applyStimulus(1, 1, 5, 0, 5, 0, 1, 0);
    repeat (5) nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("sat_stallcnt", stallCnt1, expCnt(3));
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("sat_flushcnt", flushCnt1, expCnt(3));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
